neuron_pu: RTL and testbench

NEURON_PU -- requirements
Module: neuron_pu

---
 rtl/nn_pkg.sv | 25 ++
 rtl/pu_adder_tree.sv | 46 ++++
 rtl/neuron_pu.sv | 162 ++++++++++++++++
 tb/tb_neuron_pu.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron processing unit: default geometry,
// output saturation bounds, per-beat control bundle and a constant log2 helper.
package nn_pkg;

  localparam int LANES_DEF   = 8;
  localparam int DW_DEF      = 8;
  localparam int ACC_W_DEF   = 32;
  localparam int SHIFT_DEF   = 7;
  localparam int SAT_MAX_DEF = (32'sd1 <<< (DW_DEF - 1)) - 32'sd1;
  localparam int SAT_MIN_DEF = -(32'sd1 <<< (DW_DEF - 1));

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_ctl_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/pu_adder_tree.sv
// Balanced signed adder tree over LANES packed operands, sign-extended to the
// full growth width, with a holdable output register.
module pu_adder_tree
  import nn_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IN_W  = 2 * DW_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [LANES*IN_W-1:0]               data_i,
  output logic signed [IN_W+clog2(LANES)-1:0] sum_o
);

  localparam int LV    = clog2(LANES);
  localparam int OUT_W = IN_W + LV;

  logic signed [OUT_W-1:0] sum_q;

  genvar l, n;
  for (l = 0; l <= LV; l++) begin : g_lvl
    logic signed [OUT_W-1:0] v [LANES >> l];
    for (n = 0; n < (LANES >> l); n++) begin : g_node
      if (l == 0) begin : g_leaf
        assign v[n] = {{LV{data_i[n*IN_W+IN_W-1]}}, data_i[n*IN_W +: IN_W]};
      end else begin : g_add
        assign v[n] = g_lvl[l-1].v[2*n] + g_lvl[l-1].v[2*n+1];
      end
    end
  end

  // Register the root of the tree; en low freezes the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= g_lvl[LV].v[0];
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/neuron_pu.sv
// Neuron processing unit: lane-parallel multiply, adder tree, bias-seeded
// accumulation, then shift / ReLU / saturate into a backpressured output.
module neuron_pu
  import nn_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int DW      = DW_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int RELU_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] x,
  input  logic [LANES*DW-1:0] w,
  input  logic [DW-1:0]       bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_ovf
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + clog2(LANES);
  localparam int SAT_HI = (DW == DW_DEF) ? SAT_MAX_DEF : (32'sd1 <<< (DW - 1)) - 32'sd1;
  localparam int SAT_LO = (DW == DW_DEF) ? SAT_MIN_DEF : -(32'sd1 <<< (DW - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI_A = ACC_W'(SAT_HI);
  localparam logic signed [ACC_W-1:0] SAT_LO_A = ACC_W'(SAT_LO);

  logic                    stall_s, adv_s;
  beat_ctl_t               s1_ctl_q, s2_ctl_q;
  logic [DW-1:0]           s1_bias_q, s2_bias_q;
  logic [LANES*PW-1:0]     prod_d, s1_prod_q;
  logic signed [SW-1:0]    sum_s;
  logic signed [ACC_W-1:0] acc_q, acc_d, bias_ext_s, sum_ext_s, shift_s, clip_s;
  logic                    out_valid_q, out_ovf_q, ovf_d;
  logic [DW-1:0]           out_data_q, data_d;

  // A held, unconsumed result freezes the whole pipe.
  assign stall_s  = out_valid_q & ~out_ready;
  assign adv_s    = ~stall_s;
  assign in_ready = adv_s;

  // Full-precision lane products from sign-extended operands.
  always_comb begin
    prod_d = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k*PW +: PW] = $signed({{DW{x[k*DW+DW-1]}}, x[k*DW +: DW]})
                         * $signed({{DW{w[k*DW+DW-1]}}, w[k*DW +: DW]});
    end
  end

  // Stage 1: products plus beat control and bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl_q  <= '0;
      s1_bias_q <= '0;
      s1_prod_q <= '0;
    end else if (adv_s) begin
      s1_ctl_q.valid <= in_valid;
      s1_ctl_q.first <= in_first;
      s1_ctl_q.last  <= in_last;
      s1_bias_q      <= bias;
      s1_prod_q      <= prod_d;
    end else begin
      s1_ctl_q  <= s1_ctl_q;
      s1_bias_q <= s1_bias_q;
      s1_prod_q <= s1_prod_q;
    end
  end

  pu_adder_tree #(
    .LANES (LANES),
    .IN_W  (PW)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .en     (adv_s),
    .data_i (s1_prod_q),
    .sum_o  (sum_s)
  );

  // Stage 2: control travels alongside the tree's registered sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ctl_q  <= '0;
      s2_bias_q <= '0;
    end else if (adv_s) begin
      s2_ctl_q  <= s1_ctl_q;
      s2_bias_q <= s1_bias_q;
    end else begin
      s2_ctl_q  <= s2_ctl_q;
      s2_bias_q <= s2_bias_q;
    end
  end

  // Next accumulator value and its formatted output candidate.
  always_comb begin
    bias_ext_s = {{(ACC_W-DW){s2_bias_q[DW-1]}}, s2_bias_q};
    sum_ext_s  = {{(ACC_W-SW){sum_s[SW-1]}}, sum_s};
    if (s2_ctl_q.first) begin
      acc_d = (bias_ext_s <<< SHIFT) + sum_ext_s;
    end else begin
      acc_d = acc_q + sum_ext_s;
    end
    shift_s = acc_d >>> SHIFT;
    if ((RELU_EN != 0) && shift_s[ACC_W-1]) begin
      clip_s = '0;
    end else begin
      clip_s = shift_s;
    end
    if (clip_s > SAT_HI_A) begin
      data_d = SAT_HI_A[DW-1:0];
      ovf_d  = 1'b1;
    end else if (clip_s < SAT_LO_A) begin
      data_d = SAT_LO_A[DW-1:0];
      ovf_d  = 1'b1;
    end else begin
      data_d = clip_s[DW-1:0];
      ovf_d  = 1'b0;
    end
  end

  // Stage 3: accumulate, and on a last beat publish and re-zero the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (adv_s) begin
      if (s2_ctl_q.valid) begin
        acc_q <= s2_ctl_q.last ? '0 : acc_d;
      end else begin
        acc_q <= acc_q;
      end
      if (s2_ctl_q.valid && s2_ctl_q.last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_d;
        out_ovf_q   <= ovf_d;
      end else begin
        out_valid_q <= 1'b0;
        out_data_q  <= out_data_q;
        out_ovf_q   <= out_ovf_q;
      end
    end else begin
      acc_q       <= acc_q;
      out_valid_q <= out_valid_q;
      out_data_q  <= out_data_q;
      out_ovf_q   <= out_ovf_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_pu.sv
// Self-checking bench for neuron_pu: directed scenarios plus randomized
// vectors, scored against an arithmetic model for both ReLU settings.
module tb_neuron_pu;
  import nn_pkg::*;

  localparam int L = 8;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_first, in_last, out_ready;
  logic [L*D-1:0] x, w;
  logic [D-1:0]   bias;
  logic           in_ready_a, out_valid_a, out_ovf_a;
  logic           in_ready_b, out_valid_b, out_ovf_b;
  logic [D-1:0]   out_data_a, out_data_b;

  int checks = 0;
  int failures = 0;

  int         acc_m = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic       stall_prev = 1'b0;
  logic [8:0] held = '0;
  logic       drv_done;

  always #5 clk = ~clk;

  neuron_pu #(.LANES(L), .DW(D), .ACC_W(32), .SHIFT(7), .RELU_EN(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_first(in_first), .in_last(in_last), .x(x), .w(w), .bias(bias),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a));

  neuron_pu #(.LANES(L), .DW(D), .ACC_W(32), .SHIFT(7), .RELU_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_first(in_first), .in_last(in_last), .x(x), .w(w), .bias(bias),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b));

  function automatic logic [L*D-1:0] splat(input logic [7:0] b);
    return {L{b}};
  endfunction

  function automatic int beat_sum(input logic [L*D-1:0] xv, input logic [L*D-1:0] wv);
    int s;
    s = 0;
    for (int k = 0; k < L; k++) begin
      int a;
      int b;
      a = $signed(xv[k*D +: D]);
      b = $signed(wv[k*D +: D]);
      s += a * b;
    end
    return s;
  endfunction

  // {ovf, data} for an accumulator value: floor-divide by 128, ReLU, clamp.
  function automatic logic [8:0] fmt(input int acc, input bit relu);
    int r;
    r = acc >>> 7;
    if (relu && r < 0) r = 0;
    if (r > SAT_MAX_DEF) return {1'b1, 8'h7F};
    if (r < SAT_MIN_DEF) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  // Reference model: accumulate every accepted beat, queue a result per last beat.
  always @(posedge clk) begin
    if (rst) begin
      acc_m = 0;
      exp_a.delete();
      exp_b.delete();
    end else if (in_valid && in_ready_a) begin
      int s;
      int bv;
      s  = beat_sum(x, w);
      bv = $signed(bias);
      if (in_first) acc_m = bv * 128 + s;
      else acc_m = acc_m + s;
      if (in_last) begin
        exp_a.push_back(fmt(acc_m, 1'b1));
        exp_b.push_back(fmt(acc_m, 1'b0));
        acc_m = 0;
      end
    end
  end

  // Scoreboard and handshake/stall monitor.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready_a !== !(out_valid_a && !out_ready) || in_ready_b !== in_ready_a) begin
        failures++;
        $display("FAIL in_ready got=%b/%b want=%b", in_ready_a, in_ready_b, !(out_valid_a && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if (out_valid_a !== 1'b1 || {out_ovf_a, out_data_a} !== held) begin
          failures++;
          $display("FAIL stall_hold got=%b/%h want=1/%h", out_valid_a, {out_ovf_a, out_data_a}, held);
        end
      end
      if (out_valid_a && out_ready) begin
        checks++;
        if (exp_a.size() == 0 || exp_b.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%h want=none", {out_ovf_a, out_data_a});
        end else begin
          logic [8:0] ea;
          logic [8:0] eb;
          ea = exp_a.pop_front();
          eb = exp_b.pop_front();
          if ({out_ovf_a, out_data_a} !== ea || out_valid_b !== 1'b1 || {out_ovf_b, out_data_b} !== eb) begin
            failures++;
            $display("FAIL result got=%h/%h want=%h/%h", {out_ovf_a, out_data_a}, {out_ovf_b, out_data_b}, ea, eb);
          end
        end
      end
      stall_prev = out_valid_a && !out_ready;
      held = {out_ovf_a, out_data_a};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a beat and return #1 after the edge that accepts it (valid left high).
  task automatic drive_beat(input logic f, input logic l, input logic [L*D-1:0] xv,
                            input logic [L*D-1:0] wv, input logic [D-1:0] bv);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    x = xv;
    w = wv;
    bias = bv;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=0 want=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    x = '0;
    w = '0;
    bias = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || out_ovf_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL reset got=%b/%h/%b/%b want=0/00/0/1", out_valid_a, out_data_a, out_ovf_a, in_ready_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    drive_beat(1'b1, 1'b1, splat(8'd16), splat(8'd16), 8'd10);
    idle(0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== (c == 3)) begin
        failures++;
        $display("FAIL single_latency cycle=%0d got=%b want=%b", c, out_valid_a, c == 3);
      end
    end
    checks++;
    if (out_data_a !== 8'd26 || out_ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL single got=%0d/%b want=26/0", out_data_a, out_ovf_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_multi();
    logic got;
    drive_beat(1'b1, 1'b0, splat(8'd16), splat(8'd16), 8'd10);
    idle(1);
    drive_beat(1'b0, 1'b0, splat(8'd16), splat(8'd16), 8'd99);
    drive_beat(1'b0, 1'b1, splat(8'd16), splat(8'd16), 8'd99);
    idle(0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid_a;
    end
    checks++;
    if (!got || out_data_a !== 8'd58 || out_ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL multi got=%b/%0d/%b want=1/58/0", got, out_data_a, out_ovf_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_edge_values(input logic [7:0] xb, input logic [7:0] wb,
                                  input logic [8:0] want_a, input logic [8:0] want_b);
    drive_beat(1'b1, 1'b1, splat(xb), splat(wb), 8'd0);
    idle(2);
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || {out_ovf_a, out_data_a} !== want_a || {out_ovf_b, out_data_b} !== want_b) begin
      failures++;
      $display("FAIL edge_x%h_w%h got=%h/%h want=%h/%h", xb, wb, {out_ovf_a, out_data_a},
               {out_ovf_b, out_data_b}, want_a, want_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(1'b1, 1'b1, splat(8'd16), splat(8'd16), 8'd10);
    drive_beat(1'b1, 1'b1, splat(8'd16), splat(8'd32), 8'd0);
    idle(0);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || out_data_a !== 8'd26) begin
        failures++;
        $display("FAIL bp_hold got=%b/%b/%0d want=1/0/26", out_valid_a, in_ready_a, out_data_a);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 8'd26) begin
      failures++;
      $display("FAIL bp_first got=%b/%0d want=1/26", out_valid_a, out_data_a);
    end
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 8'd32) begin
      failures++;
      $display("FAIL bp_second got=%b/%0d want=1/32", out_valid_a, out_data_a);
    end
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b want=0", out_valid_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic got;
    drive_beat(1'b1, 1'b0, splat(8'd16), splat(8'd16), 8'd50);
    drive_beat(1'b0, 1'b0, splat(8'd40), splat(8'd40), 8'd0);
    idle(0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive_beat(1'b1, 1'b1, splat(8'd16), splat(8'd16), 8'd10);
    idle(0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid_a;
    end
    checks++;
    if (!got || out_data_a !== 8'd26 || out_ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%0d/%b want=1/26/0", got, out_data_a, out_ovf_a);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_stale got=%b want=0", out_valid_a);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5000 && !drv_done; i++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int v = 0; v < 30; v++) begin
          int nb;
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive_beat((b == 0) ? ($urandom_range(0, 4) != 0) : 1'b0, b == nb - 1,
                       {$urandom, $urandom}, {$urandom, $urandom}, D'($urandom));
          end
        end
        idle(0);
        drv_done = 1'b1;
      end
    join
    for (int i = 0; i < 100 && exp_a.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL random_drain got=%0d want=0", exp_a.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_edge_values(8'hF0, 8'd16, {1'b0, 8'h00}, {1'b0, 8'hF0});
    test_edge_values(8'd127, 8'd127, {1'b1, 8'h7F}, {1'b1, 8'h7F});
    test_edge_values(8'h80, 8'd127, {1'b0, 8'h00}, {1'b1, 8'h80});
    test_backpressure();
    test_reset_mid();
    test_random();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
